os_skew_feeder: RTL and testbench
=================================

OS_SKEW_FEEDER -- requirements
Module: os_skew_feeder

Interface
REQ-001 SHALL have parameter A_H, default 32, meaning array rows / A lanes.
REQ-002 SHALL have parameter B_W, default 32, meaning array columns / B lanes.
REQ-003 SHALL have parameter WIDTH, default 8, meaning signed operand width.
REQ-004 SHALL have parameter KW, default 16, meaning beat-counter width.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk  in  1  clock, rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port in_valid  in  1  a beat (one k step) is offered.
REQ-009 SHALL have port in_ready  out  1  the beat is accepted this cycle.
REQ-010 SHALL have port in_a  in  A_H*WIDTH  column k of A; lane i = A[i][k].
REQ-011 SHALL have port in_b  in  B_W*WIDTH  row k of B; lane j = B[k][j].
REQ-012 SHALL have port in_last  in  1  qualifies the final beat of the tile.
REQ-013 SHALL have port out_a  out  A_H*WIDTH  skewed A, drives array A.
REQ-014 SHALL have port out_b  out  B_W*WIDTH  skewed B, drives array B.
REQ-015 SHALL have port out_valid  out  1  data_valid to the array.
REQ-016 SHALL have port clc  out  1  clear accumulators, one-cycle pulse.
REQ-017 SHALL have port tile_done  out  1  one-cycle pulse, last operand issued.
REQ-018 SHALL have port k_count  out  KW  beats accepted in the current or last tile.

Function
REQ-019 SHALL implement FSM IDLE->CLEAR->STREAM->FLUSH->DONE->IDLE.
REQ-020 IDLE: in_ready=0; in_valid=1 moves to CLEAR; the offered beat is not consumed.
REQ-021 CLEAR: clc=1 for exactly this cycle; in_ready=0; next state STREAM.
REQ-022 STREAM: in_ready=1 combinationally; a beat is accepted iff in_valid&&in_ready.
REQ-023 Accepted beat with in_last=1 SHALL move to FLUSH; in_last with in_valid=0 is ignored.
REQ-024 FLUSH SHALL last exactly max(A_H,B_W)-1 cycles (counter), then DONE; zero cycles when max is 1 (straight to DONE).
REQ-025 DONE: tile_done=1 for one cycle, then IDLE.
REQ-026 Lane i of A and lane j of B SHALL shift every cycle: depth i+1 and j+1 registers; A[i][k] accepted at edge E appears on out_a lane i in cycle E+i+1.
REQ-027 A STREAM cycle without acceptance (bubble) SHALL inject zeros into every lane head, preserving skew alignment.
REQ-028 IDLE/CLEAR/DONE SHALL inject zeros into lane heads.
REQ-029 out_valid SHALL be registered: 1 in the cycle after any STREAM or FLUSH cycle, else 0; bubbles do not drop it.
REQ-030 Operands SHALL pass unmodified (no sign extension, no arithmetic).
REQ-031 k_count SHALL clear in CLEAR, increment per accepted beat, saturate at 2^KW-1, hold after DONE.

Reset
REQ-032 rst=1 SHALL force state IDLE, all lane registers 0, FLUSH counter 0, k_count 0.
REQ-033 During and the cycle after reset: out_a=0, out_b=0, out_valid=0, clc=0, tile_done=0, in_ready=0.
REQ-034 Reset mid-STREAM/FLUSH SHALL abort the tile with no tile_done pulse.

Configuration
REQ-035 Macro OS_FEEDER_STATS_EN defined: k_count behaves per REQ-031.
REQ-036 Macro OS_FEEDER_STATS_EN undefined: k_count tied to 0, no counter register synthesised; port retained.

Structure
REQ-037 Package os_feeder_pkg SHALL hold the FSM state enum and the function giving FLUSH length from A_H, B_W.
REQ-038 Sub-module skew_line (parameters DEPTH, WIDTH; clk, rst, d, q) SHALL implement one lane; instantiated A_H+B_W times.

Verification (A_H=B_W=4, WIDTH=8)
REQ-039 Reset held 3 cycles with in_valid=1 -> all outputs 0, in_ready 0 throughout, clc never 1.
REQ-040 Tile K=4, in_a lane i = 10*i+k, no bubbles -> clc 1 cycle, in_ready 4 cycles, out_a lane 2 = 20 at 3 cycles after first accept, out_valid high 7 cycles, tile_done 1 cycle after FLUSH.
REQ-041 K=4 with in_valid=0 on 3rd STREAM cycle -> zeros in that slot on every lane at its skewed time, out_valid stays 1 for 8 cycles.
REQ-042 K=1 (in_last on first beat) -> STREAM 1 cycle, FLUSH 3 cycles, tile_done 5 cycles after CLEAR.
REQ-043 rst asserted on 2nd STREAM cycle -> next cycle outputs 0, state IDLE, no tile_done.
REQ-044 With OS_FEEDER_STATS_EN, the REQ-041 tile -> k_count=4 at tile_done; without the macro -> k_count=0.

Source files
------------

// File: rtl/os_feeder_pkg.sv
// rtl/os_feeder_pkg.sv - shared FSM state type and flush-length helper for the skew feeder
package os_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Cycles needed after the last beat so the deepest lane drains its final operand
  function automatic int flush_len(input int a_h, input int b_w);
    return ((a_h > b_w) ? a_h : b_w) - 1;
  endfunction

endpackage

// File: rtl/os_skew_feeder_skew_line.sv
// rtl/os_skew_feeder_skew_line.sv - one skew lane: DEPTH-register shift line
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift every cycle; the head always takes d (zeros when nothing is injected)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/os_skew_feeder.sv
// rtl/os_skew_feeder.sv - skewed operand feeder for an output-stationary array (k_count stats: OS_FEEDER_STATS_EN)
module os_skew_feeder
  import os_feeder_pkg::*;
#(
  parameter int A_H   = 32,
  parameter int B_W   = 32,
  parameter int WIDTH = 8,
  parameter int KW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_H*WIDTH-1:0] in_a,
  input  logic [B_W*WIDTH-1:0] in_b,
  input  logic               in_last,
  output logic [A_H*WIDTH-1:0] out_a,
  output logic [B_W*WIDTH-1:0] out_b,
  output logic               out_valid,
  output logic               clc,
  output logic               tile_done,
  output logic [KW-1:0]      k_count
);

  localparam int FLUSH_LEN = flush_len(A_H, B_W);
  localparam int FCW       = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  state_t           state, state_n;
  logic [FCW-1:0]   fcnt, fcnt_n;
  logic             accept;
  logic [A_H*WIDTH-1:0] head_a;
  logic [B_W*WIDTH-1:0] head_b;

  // Next-state and handshake/pulse outputs; reset masks the combinational outputs
  always_comb begin
    state_n   = state;
    fcnt_n    = fcnt;
    in_ready  = 1'b0;
    clc       = 1'b0;
    tile_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) state_n = ST_CLEAR;
      end
      ST_CLEAR: begin
        clc     = 1'b1;
        state_n = ST_STREAM;
      end
      ST_STREAM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          fcnt_n  = '0;
          state_n = (FLUSH_LEN == 0) ? ST_DONE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fcnt == FCW'(FLUSH_LEN - 1)) state_n = ST_DONE;
        else                             fcnt_n  = fcnt + FCW'(1);
      end
      ST_DONE: begin
        tile_done = 1'b1;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      clc       = 1'b0;
      tile_done = 1'b0;
    end
  end

  // State, flush counter and the registered array data_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fcnt      <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      fcnt      <= fcnt_n;
      out_valid <= (state == ST_STREAM) || (state == ST_FLUSH);
    end
  end

  // Anything other than an accepted beat feeds zeros so skew alignment is kept
  assign accept = in_valid && in_ready;
  assign head_a = accept ? in_a : '0;
  assign head_b = accept ? in_b : '0;

  for (genvar i = 0; i < A_H; i++) begin : g_lane_a
    skew_line #(.DEPTH(i + 1), .WIDTH(WIDTH)) u_line (
      .clk (clk),
      .rst (rst),
      .d   (head_a[i*WIDTH +: WIDTH]),
      .q   (out_a[i*WIDTH +: WIDTH])
    );
  end

  for (genvar j = 0; j < B_W; j++) begin : g_lane_b
    skew_line #(.DEPTH(j + 1), .WIDTH(WIDTH)) u_line (
      .clk (clk),
      .rst (rst),
      .d   (head_b[j*WIDTH +: WIDTH]),
      .q   (out_b[j*WIDTH +: WIDTH])
    );
  end

`ifdef OS_FEEDER_STATS_EN
  logic [KW-1:0] kcnt;

  // Beats accepted in the current/last tile, saturating, held until the next CLEAR
  always_ff @(posedge clk) begin
    if (rst)                                   kcnt <= '0;
    else if (state == ST_CLEAR)                kcnt <= '0;
    else if (accept && (kcnt != {KW{1'b1}}))   kcnt <= kcnt + KW'(1);
  end

  assign k_count = kcnt;
`else
  assign k_count = '0;
`endif

endmodule

// File: tb/tb_os_skew_feeder.sv
// tb/tb_os_skew_feeder.sv - randomized self-checking bench for os_skew_feeder (honours OS_FEEDER_STATS_EN)
module tb_os_skew_feeder;

  localparam int AH  = 4;
  localparam int BW  = 4;
  localparam int W   = 8;
  localparam int KWP = 3;
  localparam int LOG = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, in_ready, in_last, out_valid, clc, tile_done;
  logic [AH*W-1:0]   in_a, out_a;
  logic [BW*W-1:0]   in_b, out_b;
  logic [KWP-1:0]    k_count;

  os_skew_feeder #(.A_H(AH), .B_W(BW), .WIDTH(W), .KW(KWP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_valid (out_valid),
    .clc       (clc),
    .tile_done (tile_done),
    .k_count   (k_count)
  );

  int errors = 0;
  int checks = 0;
  int n = 0;

  logic [AH*W-1:0] hist_a [LOG];
  logic [BW*W-1:0] hist_b [LOG];
  logic [AH*W-1:0] obs_a  [LOG];
  logic [BW*W-1:0] obs_b  [LOG];
  logic            obs_ready [LOG];
  logic            obs_clc   [LOG];
  logic            obs_done  [LOG];
  logic            obs_valid [LOG];
  logic [KWP-1:0]  obs_k     [LOG];

  int s_ready, s_first_ready, s_last_ready, s_third_ready;
  int s_clc, s_clc_at, s_valid, s_first_valid, s_done, s_done_at;

  // One clock cycle: drive at negedge, observe 1ns later, log what was injected
  task automatic cycle(input logic r, input logic v, input logic last,
                       input logic [AH*W-1:0] a, input logic [BW*W-1:0] b);
    @(negedge clk);
    rst = r; in_valid = v; in_last = last; in_a = a; in_b = b;
    #1;
    if (n < LOG) begin
      obs_a[n] = out_a;  obs_b[n] = out_b;
      obs_ready[n] = in_ready; obs_clc[n] = clc; obs_done[n] = tile_done;
      obs_valid[n] = out_valid; obs_k[n] = k_count;
      hist_a[n] = (v && in_ready) ? a : '0;
      hist_b[n] = (v && in_ready) ? b : '0;
    end
    n++;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    n = 0;
  endtask

  // Reference: lane i shows the value injected i+1 cycles earlier
  function automatic logic [AH*W-1:0] exp_a(input int t);
    logic [AH*W-1:0] e;
    e = '0;
    for (int i = 0; i < AH; i++)
      if (t - i - 1 >= 0) e[i*W +: W] = hist_a[t-i-1][i*W +: W];
    return e;
  endfunction

  function automatic logic [BW*W-1:0] exp_b(input int t);
    logic [BW*W-1:0] e;
    e = '0;
    for (int j = 0; j < BW; j++)
      if (t - j - 1 >= 0) e[j*W +: W] = hist_b[t-j-1][j*W +: W];
    return e;
  endfunction

  function automatic logic [KWP-1:0] exp_k(input int k);
`ifdef OS_FEEDER_STATS_EN
    return (k > 7) ? KWP'(7) : KWP'(k);
`else
    return KWP'(0);
`endif
  endfunction

  // Offer a K-beat tile, reacting to in_ready; optional fixed/random bubbles and abort
  task automatic drive_tile(input int k_beats, input int bubble_at, input int abort_at,
                            input bit pattern, input int bubble_pct, input int trail,
                            output bit done, output logic [KWP-1:0] k_done);
    int idx, budget;
    bit bubbled, stop;
    logic v, last, r;
    logic [AH*W-1:0] a;
    logic [BW*W-1:0] b;
    idx = 0; budget = 0; bubbled = 0; stop = 0; done = 0; k_done = '0;
    while (!done && !stop && budget < 60) begin
      r = (abort_at >= 0 && idx == abort_at);
      v = (idx < k_beats);
      if (idx == bubble_at && !bubbled) v = 1'b0;
      if (idx > 0 && idx < k_beats && $urandom_range(99) < bubble_pct) v = 1'b0;
      last = v ? (idx == k_beats - 1) : 1'($urandom_range(1));
      if (pattern) begin
        for (int i = 0; i < AH; i++) a[i*W +: W] = W'(10 * i + idx);
      end else begin
        a = $urandom;
      end
      b = $urandom;
      cycle(r, v, last, a, b);
      if (r) stop = 1;
      else begin
        if (obs_ready[n-1] && v) idx++;
        if (obs_ready[n-1] && !v && idx == bubble_at) bubbled = 1;
        if (obs_done[n-1]) begin done = 1; k_done = obs_k[n-1]; end
      end
      budget++;
    end
    for (int c = 0; c < trail; c++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic summarize();
    s_ready = 0; s_first_ready = 0; s_last_ready = 0; s_third_ready = 0;
    s_clc = 0; s_clc_at = 0; s_valid = 0; s_first_valid = 0; s_done = 0; s_done_at = 0;
    for (int t = 0; t < n && t < LOG; t++) begin
      if (obs_ready[t]) begin
        if (s_ready == 0) s_first_ready = t;
        if (s_ready == 2) s_third_ready = t;
        s_last_ready = t;
        s_ready++;
      end
      if (obs_clc[t])   begin if (s_clc == 0)   s_clc_at = t;      s_clc++;   end
      if (obs_valid[t]) begin if (s_valid == 0) s_first_valid = t; s_valid++; end
      if (obs_done[t])  begin if (s_done == 0)  s_done_at = t;     s_done++;  end
    end
  endtask

  task automatic test_reset();
    n = 0;
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1, 1'($urandom_range(1)), $urandom, $urandom);
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (obs_ready[t] !== 1'b0 || obs_clc[t] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hs t=%0d in_ready=%b clc=%b required 0 0", t, obs_ready[t], obs_clc[t]);
      end
    end
    for (int t = 1; t < 4; t++) begin
      checks++;
      if (obs_a[t] !== '0 || obs_b[t] !== '0 || obs_valid[t] !== 1'b0 ||
          obs_done[t] !== 1'b0 || obs_k[t] !== '0) begin
        errors++;
        $display("FAIL reset_out t=%0d out_a=%h out_b=%h out_valid=%b tile_done=%b k_count=%0d required all 0",
                 t, obs_a[t], obs_b[t], obs_valid[t], obs_done[t], obs_k[t]);
      end
    end
  endtask

  task automatic test_tile();
    bit done; logic [KWP-1:0] kd;
    do_reset();
    drive_tile(4, -1, -1, 1'b1, 0, 2, done, kd);
    summarize();
    checks++; if (!done) begin errors++; $display("FAIL tile_timeout tile_done=0 required 1"); end
    checks++; if (s_clc != 1 || s_clc_at != s_first_ready - 1) begin errors++;
      $display("FAIL tile_clc count=%0d at=%0d required 1 at %0d", s_clc, s_clc_at, s_first_ready - 1); end
    checks++; if (s_ready != 4) begin errors++; $display("FAIL tile_ready cycles=%0d required 4", s_ready); end
    checks++; if (obs_a[s_first_ready+3][23:16] !== 8'd20) begin errors++;
      $display("FAIL tile_lane2 value=%0d required 20", obs_a[s_first_ready+3][23:16]); end
    checks++; if (s_valid != 7 || s_first_valid != s_first_ready + 1) begin errors++;
      $display("FAIL tile_valid cycles=%0d first=%0d required 7 first %0d", s_valid, s_first_valid, s_first_ready + 1); end
    checks++; if (s_done != 1 || s_done_at != s_last_ready + 4) begin errors++;
      $display("FAIL tile_done count=%0d at=%0d required 1 at %0d", s_done, s_done_at, s_last_ready + 4); end
    checks++; if (kd !== exp_k(4)) begin errors++; $display("FAIL tile_kcount value=%0d required %0d", kd, exp_k(4)); end
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs_a[t] !== exp_a(t) || obs_b[t] !== exp_b(t)) begin errors++;
        $display("FAIL tile_data t=%0d out_a=%h out_b=%h required %h %h", t, obs_a[t], obs_b[t], exp_a(t), exp_b(t)); end
    end
  endtask

  task automatic test_bubble();
    bit done; logic [KWP-1:0] kd; bit bad;
    do_reset();
    drive_tile(4, 2, -1, 1'b0, 0, 2, done, kd);
    summarize();
    checks++; if (!done) begin errors++; $display("FAIL bubble_timeout tile_done=0 required 1"); end
    checks++; if (s_ready != 5) begin errors++; $display("FAIL bubble_ready cycles=%0d required 5", s_ready); end
    checks++; if (s_valid != 8) begin errors++; $display("FAIL bubble_valid cycles=%0d required 8", s_valid); end
    bad = 0;
    for (int i = 0; i < AH; i++)
      if (obs_a[s_third_ready+i+1][i*W +: W] !== '0 || obs_b[s_third_ready+i+1][i*W +: W] !== '0) bad = 1;
    checks++; if (bad) begin errors++; $display("FAIL bubble_slot nonzero lane value in bubble slot required 0"); end
    checks++; if (s_done_at != s_last_ready + 4) begin errors++;
      $display("FAIL bubble_done at=%0d required %0d", s_done_at, s_last_ready + 4); end
    checks++; if (kd !== exp_k(4)) begin errors++; $display("FAIL bubble_kcount value=%0d required %0d", kd, exp_k(4)); end
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs_a[t] !== exp_a(t) || obs_b[t] !== exp_b(t)) begin errors++;
        $display("FAIL bubble_data t=%0d out_a=%h out_b=%h required %h %h", t, obs_a[t], obs_b[t], exp_a(t), exp_b(t)); end
    end
  endtask

  task automatic test_single();
    bit done; logic [KWP-1:0] kd;
    do_reset();
    drive_tile(1, -1, -1, 1'b0, 0, 2, done, kd);
    summarize();
    checks++; if (!done) begin errors++; $display("FAIL single_timeout tile_done=0 required 1"); end
    checks++; if (s_ready != 1) begin errors++; $display("FAIL single_ready cycles=%0d required 1", s_ready); end
    checks++; if (s_done != 1 || s_done_at != s_clc_at + 5) begin errors++;
      $display("FAIL single_done count=%0d at=%0d required 1 at %0d", s_done, s_done_at, s_clc_at + 5); end
    checks++; if (s_valid != 4) begin errors++; $display("FAIL single_valid cycles=%0d required 4", s_valid); end
    checks++; if (kd !== exp_k(1)) begin errors++; $display("FAIL single_kcount value=%0d required %0d", kd, exp_k(1)); end
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs_a[t] !== exp_a(t) || obs_b[t] !== exp_b(t)) begin errors++;
        $display("FAIL single_data t=%0d out_a=%h out_b=%h required %h %h", t, obs_a[t], obs_b[t], exp_a(t), exp_b(t)); end
    end
  endtask

  task automatic test_abort();
    bit done; logic [KWP-1:0] kd; int t0;
    do_reset();
    drive_tile(4, -1, 1, 1'b0, 0, 0, done, kd);
    t0 = n;
    for (int c = 0; c < 11; c++) cycle(1'b0, 1'b0, 1'($urandom_range(1)), $urandom, $urandom);
    summarize();
    checks++; if (s_ready != 1 || s_done != 0) begin errors++;
      $display("FAIL abort_fsm ready_cycles=%0d tile_done=%0d required 1 0", s_ready, s_done); end
    checks++;
    if (obs_a[t0] !== '0 || obs_b[t0] !== '0 || obs_valid[t0] !== 1'b0 || obs_ready[t0] !== 1'b0 ||
        obs_clc[t0] !== 1'b0 || obs_k[t0] !== '0) begin errors++;
      $display("FAIL abort_next out_a=%h out_b=%h out_valid=%b in_ready=%b clc=%b k_count=%0d required all 0",
               obs_a[t0], obs_b[t0], obs_valid[t0], obs_ready[t0], obs_clc[t0], obs_k[t0]); end
    for (int t = t0; t < n; t++) begin
      checks++;
      if (obs_a[t] !== '0 || obs_b[t] !== '0 || obs_valid[t] !== 1'b0) begin errors++;
        $display("FAIL abort_idle t=%0d out_a=%h out_b=%h out_valid=%b required 0", t, obs_a[t], obs_b[t], obs_valid[t]); end
    end
  endtask

  task automatic test_back_to_back();
    bit done; logic [KWP-1:0] kd; int kb;
    do_reset();
    for (int tile = 0; tile < 3; tile++) begin
      kb = $urandom_range(1, 9);
      drive_tile(kb, -1, -1, 1'b0, 30, (tile == 2) ? 2 : 0, done, kd);
      checks++; if (!done) begin errors++; $display("FAIL b2b_timeout tile=%0d tile_done=0 required 1", tile); end
      checks++; if (kd !== exp_k(kb)) begin errors++;
        $display("FAIL b2b_kcount tile=%0d value=%0d required %0d", tile, kd, exp_k(kb)); end
    end
    summarize();
    checks++; if (s_done != 3 || s_clc != 3) begin errors++;
      $display("FAIL b2b_pulses tile_done=%0d clc=%0d required 3 3", s_done, s_clc); end
    checks++; if (s_valid != s_ready + 9) begin errors++;
      $display("FAIL b2b_valid cycles=%0d required %0d", s_valid, s_ready + 9); end
    for (int t = 0; t < n && t < LOG; t++) begin
      checks++;
      if (obs_a[t] !== exp_a(t) || obs_b[t] !== exp_b(t)) begin errors++;
        $display("FAIL b2b_data t=%0d out_a=%h out_b=%h required %h %h", t, obs_a[t], obs_b[t], exp_a(t), exp_b(t)); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
    test_reset();
    test_tile();
    test_bubble();
    test_single();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
